// File: rtl/multi_cycle_ctr_if.sv
// Control bundle between the multi-cycle FSM and the shared MIPS datapath.
// Latency: pure wiring, no storage.
// Backpressure: MemReady from the memory side stalls the FSM in its memory states.
//
// Signals:
//   OpCode/Funct  IR fields observed by the controller
//   MemReady      memory completes the current read/write this cycle
//   PCWrite..IllegalOp, State  datapath controls and status from the controller
// Modports:
//   master  the controller (consumes IR fields / MemReady, drives controls)
//   slave   the datapath side (drives IR fields / MemReady, consumes controls)
interface multi_cycle_ctr_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       MemReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [1:0] PCSource;
    logic       InstrDone;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  OpCode, Funct, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl,
               PCSource, InstrDone, IllegalOp, State
    );

    modport slave (
        output OpCode, Funct, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUControl,
               PCSource, InstrDone, IllegalOp, State
    );
endinterface

// File: rtl/multi_cycle_ctr.sv
// Moore control FSM sequencing the shared multi-cycle MIPS datapath.
// Latency: FETCH->FETCH lw 5, sw/R/addi 4, beq/j/illegal 3 cycles (+1 per MemReady=0 cycle).
// Backpressure: holds in FETCH/MEMRD/MEMWR while MemReady=0 with strobes and IorD stable.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, forces IDLE (all outputs 0)
//   io_ctl  multi_cycle_ctr_if.master: OpCode/Funct/MemReady in, datapath controls out
// Build option: define MULTI_CYCLE_ADDI_EN to decode addi (001000) via ADDIEX/ADDIWB;
// otherwise addi traps like any other unsupported opcode.
module multi_cycle_ctr (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_cycle_ctr_if.master      io_ctl
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
`ifdef MULTI_CYCLE_ADDI_EN
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
`endif
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTI_CYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_control;
    logic [1:0] w_pc_source;
    logic       w_instr_done;
    logic       w_illegal_op;

    // State register; reset lands in IDLE immediately, aborting any pending memory access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore outputs. Only FETCH/MEMWR look at MemReady and only EXEC
    // looks at Funct for its outputs; everything else is a function of r_state.
    always_comb begin
        w_next_state    = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_B;
        w_alu_control   = ALU_ADD;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;
        w_illegal_op    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Reset/idle presents an all-zero control word, ALUControl included.
                w_alu_control = 4'b0000;
                w_next_state  = S_FETCH;
            end

            S_FETCH: begin
                // ALU computes PC+4 every fetch cycle; the PC/IR only load on completion.
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                if (io_ctl.MemReady) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            S_DECODE: begin
                // Speculatively form the branch target into ALUOut for a possible beq.
                w_alu_src_b = SRCB_IMMSH;
                case (io_ctl.OpCode)
                    OP_LW,
                    OP_SW:    w_next_state = S_MEMADR;
                    OP_RTYPE: w_next_state = S_EXEC;
                    OP_BEQ:   w_next_state = S_BRANCH;
                    OP_J:     w_next_state = S_JUMP;
`ifdef MULTI_CYCLE_ADDI_EN
                    OP_ADDI:  w_next_state = S_ADDIEX;
`endif
                    default:  w_next_state = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                // Only lw/sw reach here, so anything that is not sw is a load.
                w_next_state = (io_ctl.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                w_mem_read   = 1'b1;
                w_iord       = 1'b1;
                w_next_state = io_ctl.MemReady ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWR: begin
                // Store retires in the cycle the memory accepts it.
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (io_ctl.MemReady) begin
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end

            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_B;
                w_next_state = S_RWB;
                case (io_ctl.Funct)
                    FN_ADD:  w_alu_control = ALU_ADD;
                    FN_SUB:  w_alu_control = ALU_SUB;
                    FN_AND:  w_alu_control = ALU_AND;
                    FN_OR:   w_alu_control = ALU_OR;
                    FN_SLT:  w_alu_control = ALU_SLT;
                    default: w_next_state  = S_TRAP;
                endcase
            end

            S_RWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                // Compare A-B; the datapath gates the PC load with Zero, so the FSM
                // path is the same for taken and not-taken branches.
                w_alu_src_a     = 1'b1;
                w_alu_control   = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
                w_instr_done    = 1'b1;
                w_next_state    = S_FETCH;
            end

            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_JUMP;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end

`ifdef MULTI_CYCLE_ADDI_EN
            S_ADDIEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = S_ADDIWB;
            end

            S_ADDIWB: begin
                // rt destination, ALUOut source: RegDst and MemToReg stay 0.
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
`endif

            default: begin
                // TRAP and every unused encoding: flag, write nothing, move on.
                // PC already advanced in FETCH, so the instruction is skipped.
                w_illegal_op = 1'b1;
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign io_ctl.PCWrite     = w_pc_write;
    assign io_ctl.PCWriteCond = w_pc_write_cond;
    assign io_ctl.IorD        = w_iord;
    assign io_ctl.MemRead     = w_mem_read;
    assign io_ctl.MemWrite    = w_mem_write;
    assign io_ctl.IRWrite     = w_ir_write;
    assign io_ctl.MemToReg    = w_mem_to_reg;
    assign io_ctl.RegDst      = w_reg_dst;
    assign io_ctl.RegWrite    = w_reg_write;
    assign io_ctl.ALUSrcA     = w_alu_src_a;
    assign io_ctl.ALUSrcB     = w_alu_src_b;
    assign io_ctl.ALUControl  = w_alu_control;
    assign io_ctl.PCSource    = w_pc_source;
    assign io_ctl.InstrDone   = w_instr_done;
    assign io_ctl.IllegalOp   = w_illegal_op;
    assign io_ctl.State       = r_state;

endmodule
